instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit_perf_counter.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch definitions: opcodes, IR field positions, fetch states.
// Optional perf counters are enabled with macro FETCH_PERF_CNT_EN.
package instruction_fetch_unit_pkg;

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_STO = 6'h01;
   localparam logic [5:0] OP_JMP = 6'h0A;

   localparam int OPCODE_MSB = 29;
   localparam int OPCODE_LSB = 24;
   localparam int TARGET_MSB = 23;
   localparam int TARGET_LSB = 16;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_t;

   // Label fields are 8 bits; addresses are 16, so zero-extend.
   function automatic logic [15:0] target_of(
      input logic [29:0] w
   );
      return {8'h00, w[TARGET_MSB:TARGET_LSB]};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: ROM address/data, redirect/stall inputs, IR outputs.
// master = fetch unit, slave = PC/ROM/decode environment.
interface instruction_fetch_unit_if;

   logic [15:0] oIP;
   logic [29:0] iInstruction;
   logic        iStall;
   logic        iBranchTaken;
   logic [15:0] iBranchTarget;
   logic [29:0] oIR;
   logic [15:0] oIRAddr;
   logic        oIRValid;
   logic        oHalt;

   modport master (
      output oIP, oIR, oIRAddr, oIRValid, oHalt,
      input  iInstruction, iStall,
      input  iBranchTaken, iBranchTarget
   );

   modport slave (
      input  oIP, oIR, oIRAddr, oIRValid, oHalt,
      output iInstruction, iStall,
      output iBranchTaken, iBranchTarget
   );

endinterface

// File: rtl/instruction_fetch_unit_perf_counter.sv
// fetch_perf_counter: two saturating 32-bit event counters.
// Ports: Clock, Reset (sync, active-low), iFetch/iBubble, counts out.
module fetch_perf_counter (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iFetch,
   input  logic        iBubble,
   output logic [31:0] oFetchCount,
   output logic [31:0] oBubbleCount
);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         oFetchCount  <= '0;
         oBubbleCount <= '0;
      end else begin
         if (iFetch && oFetchCount != '1)
            oFetchCount <= oFetchCount + 32'd1;
         if (iBubble && oBubbleCount != '1)
            oBubbleCount <= oBubbleCount + 32'd1;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, IR, redirect flush, stall hold, self-loop halt.
// Ports: Clock, Reset (sync, active-low), bus (master); FETCH_PERF_CNT_EN adds counters.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_ADDR = 16'd0,
   parameter logic [29:0] NOP_WORD   = {OP_NOP, 24'b0}
) (
   input  logic                      Clock,
   input  logic                      Reset,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]               oFetchCount,
   output logic [31:0]               oBubbleCount,
`endif
   instruction_fetch_unit_if.master  bus
);

   fetch_state_t state_q, state_d;

   logic [15:0] pc_q, pc_d;
   logic [29:0] ir_q, ir_d;
   logic [15:0] ir_addr_q, ir_addr_d;
   logic        valid_q, valid_d;
   logic        halt_q, halt_d;
   logic        halt_hit;

   // JMP to its own address, only when that word is actually issuing.
   assign halt_hit = valid_q
                  && ir_q[OPCODE_MSB:OPCODE_LSB] == OP_JMP
                  && target_of(ir_q) == ir_addr_q
                  && !bus.iStall;

   always_ff @(posedge Clock) begin
      if (!Reset) state_q <= S_FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      ir_addr_d = ir_addr_q;
      valid_d   = valid_q;
      halt_d    = halt_q;
      unique case (state_q)
         S_FILL: begin
            // Redirects are ignored: nothing has executed yet.
            ir_d      = bus.iInstruction;
            ir_addr_d = pc_q;
            pc_d      = pc_q + 16'd1;
            valid_d   = 1'b1;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (halt_hit) begin
               state_d = S_HALT;
               halt_d  = 1'b1;
            end else if (bus.iBranchTaken) begin
               pc_d    = bus.iBranchTarget;
               ir_d    = NOP_WORD;
               valid_d = 1'b0;
            end else if (!bus.iStall) begin
               ir_d      = bus.iInstruction;
               ir_addr_d = pc_q;
               pc_d      = pc_q + 16'd1;
               valid_d   = 1'b1;
            end
         end
         S_HALT: begin
            halt_d = 1'b1;
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         pc_q      <= RESET_ADDR;
         ir_q      <= NOP_WORD;
         ir_addr_q <= 16'd0;
         valid_q   <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         ir_addr_q <= ir_addr_d;
         valid_q   <= valid_d;
         halt_q    <= halt_d;
      end
   end

   assign bus.oIP      = pc_q;
   assign bus.oIR      = ir_q;
   assign bus.oIRAddr  = ir_addr_q;
   assign bus.oIRValid = valid_q;
   assign bus.oHalt    = halt_q;

`ifdef FETCH_PERF_CNT_EN
   logic run_q;
   logic fetch_inc;
   logic bubble_inc;

   assign run_q = state_q == S_RUN && !halt_hit;

   assign fetch_inc = state_q == S_FILL
                   || (run_q && !bus.iBranchTaken
                             && !bus.iStall);

   // A branch+stall edge is one flush, counted once.
   assign bubble_inc = run_q
                    && (bus.iBranchTaken || bus.iStall);

   fetch_perf_counter u_perf (
      .Clock        (Clock),
      .Reset        (Reset),
      .iFetch       (fetch_inc),
      .iBubble      (bubble_inc),
      .oFetchCount  (oFetchCount),
      .oBubbleCount (oBubbleCount)
   );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
// ROM model: word[A] = {STO, A[7:0], A5A5}, except a JMP-to-self at 24.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   localparam logic [29:0] NOPW = {OP_NOP, 24'b0};

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   instruction_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt;
   logic [31:0] bcnt;
`endif

   instruction_fetch_unit dut (
      .Clock        (clk),
      .Reset        (rst_n),
`ifdef FETCH_PERF_CNT_EN
      .oFetchCount  (fcnt),
      .oBubbleCount (bcnt),
`endif
      .bus          (bus)
   );

   function automatic logic [29:0] rom(input logic [15:0] a);
      if (a == 16'd24) return {OP_JMP, 8'd24, 16'h0000};
      return {OP_STO, a[7:0], 16'hA5A5};
   endfunction

   assign bus.iInstruction = rom(bus.oIP);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.iStall = 1'b0;
      bus.iBranchTaken = 1'b0;
      bus.iBranchTarget = 16'd0;
      tick();
      tick();
      checks++;
      if (bus.oIP !== 16'd0) begin
         failures++;
         $display("FAIL reset_ip got=%h exp=0", bus.oIP);
      end
      checks++;
      if (bus.oIR !== NOPW || bus.oIRAddr !== 16'd0) begin
         failures++;
         $display("FAIL reset_ir got=%h/%h exp=%h/0",
                  bus.oIR, bus.oIRAddr, NOPW);
      end
      checks++;
      if (bus.oIRValid !== 1'b0 || bus.oHalt !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b%b exp=00",
                  bus.oIRValid, bus.oHalt);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_freerun();
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (bus.oIR !== rom(16'(k - 1))
             || bus.oIRAddr !== 16'(k - 1)
             || bus.oIRValid !== 1'b1
             || bus.oIP !== 16'(k)) begin
            failures++;
            $display("FAIL freerun_%0d got=%h/%h/%b/%h", k,
                     bus.oIR, bus.oIRAddr, bus.oIRValid, bus.oIP);
         end
      end
   endtask

   task automatic test_stall();
      tick();
      tick();
      bus.iStall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (bus.oIP !== 16'd7 || bus.oIR !== rom(16'd6)
             || bus.oIRAddr !== 16'd6
             || bus.oIRValid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold_%0d got=%h/%h/%h exp=7/%h/6",
                     k, bus.oIP, bus.oIR, bus.oIRAddr, rom(16'd6));
         end
      end
      bus.iStall = 1'b0;
      tick();
      checks++;
      if (bus.oIR !== rom(16'd7) || bus.oIRAddr !== 16'd7
          || bus.oIP !== 16'd8) begin
         failures++;
         $display("FAIL stall_release got=%h/%h/%h exp=%h/7/8",
                  bus.oIR, bus.oIRAddr, bus.oIP, rom(16'd7));
      end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (bus.oIP !== 16'd12) begin
         failures++;
         $display("FAIL branch_pre got=%h exp=c", bus.oIP);
      end
      bus.iBranchTaken = 1'b1;
      bus.iBranchTarget = 16'd180;
      tick();
      bus.iBranchTaken = 1'b0;
      checks++;
      if (bus.oIP !== 16'd180 || bus.oIR !== NOPW
          || bus.oIRValid !== 1'b0) begin
         failures++;
         $display("FAIL branch_bubble got=%h/%h/%b exp=b4/%h/0",
                  bus.oIP, bus.oIR, bus.oIRValid, NOPW);
      end
      tick();
      checks++;
      if (bus.oIR !== rom(16'd180) || bus.oIRAddr !== 16'd180
          || bus.oIRValid !== 1'b1 || bus.oIP !== 16'd181) begin
         failures++;
         $display("FAIL branch_target got=%h/%h/%b/%h",
                  bus.oIR, bus.oIRAddr, bus.oIRValid, bus.oIP);
      end
   endtask

   task automatic test_branch_stall();
      bus.iBranchTaken = 1'b1;
      bus.iStall = 1'b1;
      bus.iBranchTarget = 16'd41;
      tick();
      bus.iBranchTaken = 1'b0;
      checks++;
      if (bus.oIP !== 16'd41 || bus.oIR !== NOPW
          || bus.oIRValid !== 1'b0) begin
         failures++;
         $display("FAIL brstall_redirect got=%h/%h/%b exp=29/%h/0",
                  bus.oIP, bus.oIR, bus.oIRValid, NOPW);
      end
      tick();
      checks++;
      if (bus.oIP !== 16'd41 || bus.oIRValid !== 1'b0) begin
         failures++;
         $display("FAIL brstall_hold got=%h/%b exp=29/0",
                  bus.oIP, bus.oIRValid);
      end
      bus.iStall = 1'b0;
      tick();
      checks++;
      if (bus.oIR !== rom(16'd41) || bus.oIRAddr !== 16'd41
          || bus.oIP !== 16'd42) begin
         failures++;
         $display("FAIL brstall_resume got=%h/%h/%h",
                  bus.oIR, bus.oIRAddr, bus.oIP);
      end
   endtask

   task automatic test_wrap();
      bus.iBranchTaken = 1'b1;
      bus.iBranchTarget = 16'hFFFF;
      tick();
      bus.iBranchTaken = 1'b0;
      checks++;
      if (bus.oIP !== 16'hFFFF) begin
         failures++;
         $display("FAIL wrap_top got=%h exp=ffff", bus.oIP);
      end
      tick();
      checks++;
      if (bus.oIP !== 16'h0000 || bus.oIRAddr !== 16'hFFFF
          || bus.oIR !== rom(16'hFFFF)) begin
         failures++;
         $display("FAIL wrap_zero got=%h/%h/%h",
                  bus.oIP, bus.oIRAddr, bus.oIR);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fcnt !== 32'd15 || bcnt !== 32'd7) begin
         failures++;
         $display("FAIL perf_counts got=%0d/%0d exp=15/7",
                  fcnt, bcnt);
      end
`endif
   endtask

   task automatic test_halt();
      logic [29:0] jw;
      jw = rom(16'd24);
      bus.iBranchTaken = 1'b1;
      bus.iBranchTarget = 16'd24;
      tick();
      bus.iBranchTaken = 1'b0;
      tick();
      checks++;
      if (bus.oIR !== jw || bus.oIRValid !== 1'b1
          || bus.oHalt !== 1'b0 || bus.oIP !== 16'd25) begin
         failures++;
         $display("FAIL halt_load got=%h/%b/%b/%h",
                  bus.oIR, bus.oIRValid, bus.oHalt, bus.oIP);
      end
      tick();
      checks++;
      if (bus.oHalt !== 1'b1 || bus.oIP !== 16'd25) begin
         failures++;
         $display("FAIL halt_set got=%b/%h exp=1/19",
                  bus.oHalt, bus.oIP);
      end
      for (int k = 0; k < 10; k++) begin
         bus.iBranchTaken = 1'($urandom_range(0, 1));
         bus.iBranchTarget = 16'($urandom_range(0, 255));
         tick();
         checks++;
         if (bus.oHalt !== 1'b1 || bus.oIP !== 16'd25
             || bus.oIR !== jw || bus.oIRAddr !== 16'd24) begin
            failures++;
            $display("FAIL halt_frozen_%0d got=%b/%h/%h/%h", k,
                     bus.oHalt, bus.oIP, bus.oIR, bus.oIRAddr);
         end
      end
      bus.iBranchTaken = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fcnt !== 32'd16 || bcnt !== 32'd8) begin
         failures++;
         $display("FAIL perf_halt got=%0d/%0d exp=16/8",
                  fcnt, bcnt);
      end
`endif
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus.oHalt !== 1'b0 || bus.oIP !== 16'd0
          || bus.oIRValid !== 1'b0) begin
         failures++;
         $display("FAIL halt_reset got=%b/%h/%b exp=0/0/0",
                  bus.oHalt, bus.oIP, bus.oIRValid);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_freerun();
      test_stall();
      test_branch();
      test_branch_stall();
      test_wrap();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
